// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl -- issue/retire controller around the multiplier for an
// RV32M/RV64M-style execute lane.
//
// Requests are taken on a valid/ready handshake and registered into stage 0.
// The multiplier then runs with a fixed latency and cannot stall. A sideband
// shift register carries valid/op/tag/a_sign/b alongside it. The result is
// selected and corrected per opcode, then written into an output FIFO. Issue
// is throttled on total occupancy (in flight + buffered). Every result that
// is in flight therefore always has a FIFO slot.
//
// Latency: a request accepted in cycle k first shows out_valid in cycle
// k+2+MUL_PIPE, provided the FIFO is empty.
//
// Parameters:
//   WIDTH         operand/result width (16, 32 or 64)
//   MUL_PIPE      internal multiplier pipe stages (0 or 1)
//   CPA_ALGORITHM final adder inside mul: 0 ripple-carry, 1 carry-lookahead
//   TAG_WIDTH     opaque request tag width
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_op                      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b, in_tag         rs1, rs2, request tag
//   out_valid/out_ready        result handshake
//   out_result, out_tag        selected result and its tag
//   busy                       any op in flight or buffered
//   stat_ops, stat_stall       (only with MUL_ISSUE_CTRL_STATS_EN) accept
//                              count and out_valid && !out_ready cycle count
//
// Optional feature macro: MUL_ISSUE_CTRL_STATS_EN

// mul -- WIDTH x WIDTH multiplier producing the full 2*WIDTH product split
// into lower/upper halves. When unsign=0 both operands are signed; when
// unsign=1 both are unsigned. The product is formed from two partial
// products, split on the low/high half of b. The pair can optionally be
// registered. The final carry-propagate add uses the selected adder.
// Internal flops carry no reset.
module mul #(
  parameter int WIDTH         = 16,
  parameter int PIPE_STAGE_0  = 1,
  parameter int CPA_ALGORITHM = 1
) (
  input  logic             clk,
  input  logic             unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lower,
  output logic [WIDTH-1:0] upper
);
  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  logic [W2-1:0] a_ext, b_ext, b_lo, b_hi;
  logic [W2-1:0] pp_lo, pp_hi;
  logic [W2-1:0] s_lo, s_hi;
  logic [W2-1:0] sum;

  always_comb begin
    a_ext = unsign ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    b_ext = unsign ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    b_lo  = '0;
    b_lo[HALF-1:0] = b[HALF-1:0];
    b_hi  = b_ext;
    b_hi[HALF-1:0] = '0;
    // a*b mod 2^W2 = a*b_lo + a*b_hi, with b_lo + b_hi = b_ext
    pp_lo = a_ext * b_lo;
    pp_hi = a_ext * b_hi;
  end

  if (PIPE_STAGE_0 != 0) begin : g_pipe
    always_ff @(posedge clk) begin
      s_lo <= pp_lo;
      s_hi <= pp_hi;
    end
  end else begin : g_nopipe
    always_comb begin
      s_lo = pp_lo;
      s_hi = pp_hi;
    end
  end

  if (CPA_ALGORITHM == 0) begin : g_rca
    logic carry;
    always_comb begin
      carry = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < W2; i++) begin
        sum[i] = s_lo[i] ^ s_hi[i] ^ carry;
        carry  = (s_lo[i] & s_hi[i]) | (carry & (s_lo[i] ^ s_hi[i]));
      end
    end
  end else begin : g_cla
    always_comb sum = s_lo + s_hi;
  end

  always_comb begin
    lower = sum[WIDTH-1:0];
    upper = sum[W2-1:WIDTH];
  end
endmodule

module mul_issue_ctrl #(
  parameter int WIDTH         = 16,
  parameter int MUL_PIPE      = 1,
  parameter int CPA_ALGORITHM = 1,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
`ifdef MUL_ISSUE_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);
  localparam int DEPTH = 3 + MUL_PIPE;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  if (WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("mul_issue_ctrl: WIDTH must be 16, 32 or 64");
  end

  logic accept, pop, push;

  // Stage 0 request register
  logic                 s0_valid;
  logic [1:0]           s0_op;
  logic [WIDTH-1:0]     s0_a, s0_b;
  logic [TAG_WIDTH-1:0] s0_tag;

  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= accept;
    if (accept) begin
      s0_op  <= in_op;
      s0_a   <= in_a;
      s0_b   <= in_b;
      s0_tag <= in_tag;
    end
  end

  logic [WIDTH-1:0] mul_lower, mul_upper;

  // MULHSU runs through the unsigned multiplier and is corrected afterwards.
  mul #(
    .WIDTH        (WIDTH),
    .PIPE_STAGE_0 (MUL_PIPE),
    .CPA_ALGORITHM(CPA_ALGORITHM)
  ) u_mul (
    .clk   (clk),
    .unsign(s0_op[1]),
    .a     (s0_a),
    .b     (s0_b),
    .lower (mul_lower),
    .upper (mul_upper)
  );

  // Sideband aligned with the multiplier output
  logic                 wb_valid;
  logic [1:0]           wb_op;
  logic [TAG_WIDTH-1:0] wb_tag;
  logic                 wb_a_sign;
  logic [WIDTH-1:0]     wb_b;

  if (MUL_PIPE != 0) begin : g_side_pipe
    logic                 s1_valid;
    logic [1:0]           s1_op;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic                 s1_a_sign;
    logic [WIDTH-1:0]     s1_b;

    always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= s0_valid;
      s1_op     <= s0_op;
      s1_tag    <= s0_tag;
      s1_a_sign <= s0_a[WIDTH-1];
      s1_b      <= s0_b;
    end

    always_comb begin
      wb_valid  = s1_valid;
      wb_op     = s1_op;
      wb_tag    = s1_tag;
      wb_a_sign = s1_a_sign;
      wb_b      = s1_b;
    end
  end else begin : g_side_comb
    always_comb begin
      wb_valid  = s0_valid;
      wb_op     = s0_op;
      wb_tag    = s0_tag;
      wb_a_sign = s0_a[WIDTH-1];
      wb_b      = s0_b;
    end
  end

  // For signed a and unsigned b, the high half is the unsigned high half
  // minus b whenever a is negative.
  logic [WIDTH-1:0] wb_corr, wb_result;

  always_comb begin
    wb_corr = wb_a_sign ? wb_b : '0;
    case (wb_op)
      2'b00:   wb_result = mul_lower;
      2'b10:   wb_result = mul_upper - wb_corr;
      default: wb_result = mul_upper;
    endcase
  end

  // Output FIFO
  logic [WIDTH-1:0]     res_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic [CW-1:0]        occ;
  logic [WIDTH-1:0]     hold_result;
  logic [TAG_WIDTH-1:0] hold_tag;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    out_valid  = (fifo_cnt != '0);
    out_result = out_valid ? res_mem[rd_ptr] : hold_result;
    out_tag    = out_valid ? tag_mem[rd_ptr] : hold_tag;
    pop        = out_valid && out_ready;
    push       = wb_valid;
    in_ready   = !rst && (occ < CW'(DEPTH));
    accept     = in_valid && in_ready;
    busy       = (occ != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      hold_result <= '0;
      hold_tag    <= '0;
    end else begin
      if (push) begin
        res_mem[wr_ptr] <= wb_result;
        tag_mem[wr_ptr] <= wb_tag;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        hold_result <= res_mem[rd_ptr];
        hold_tag    <= tag_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt == CW'(DEPTH))));
  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ <= CW'(DEPTH));

`ifdef MUL_ISSUE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (accept)                 stat_ops   <= stat_ops + 32'd1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;
  localparam int W     = 16;
  localparam int MP    = 1;
  localparam int TW    = 4;
  localparam int L     = 2 + MP;
  localparam int DEPTH = 3 + MP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef MUL_ISSUE_CTRL_STATS_EN
  logic [31:0]   stat_ops, stat_stall;
`endif

  int n_pass   = 0;
  int n_checks = 0;
  int unsigned n_acc   = 0;
  int unsigned n_stall = 0;

  logic [W-1:0]  exp_r[$];
  logic [TW-1:0] exp_t[$];

  always #5 clk = ~clk;

  mul_issue_ctrl #(
    .WIDTH        (W),
    .MUL_PIPE     (MP),
    .CPA_ALGORITHM(1),
    .TAG_WIDTH    (TW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy)
`ifdef MUL_ISSUE_CTRL_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_stall(stat_stall)
`endif
  );

  // Golden model: full 2W-bit product with per-opcode operand extension.
  function automatic logic [W-1:0] golden(input logic [1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] ae, be, p;
    ae = (op == 2'b11) ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    be = op[1] ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    p  = ae * be;
    return (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // One clock: inputs already driven; sample at negedge, return after posedge+1.
  task automatic cycle(output logic rdy, output logic ov,
                       output logic [W-1:0] r, output logic [TW-1:0] t);
    @(negedge clk);
    rdy = in_ready;
    ov  = out_valid;
    r   = out_result;
    t   = out_tag;
    if (rst) begin
      n_acc   = 0;
      n_stall = 0;
    end else begin
      if (in_valid && in_ready)   n_acc++;
      if (out_valid && !out_ready) n_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1 and wait (bounded) for its result.
  task automatic issue_one(input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] tag,
                           output int lat, output logic [W-1:0] r,
                           output logic [TW-1:0] t);
    logic rdy, ov;
    logic [W-1:0] rr;
    logic [TW-1:0] tt;
    lat = -1;
    r = '0;
    t = '0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    cycle(rdy, ov, rr, tt);
    in_valid = 1'b0;
    if (rdy) begin
      for (int c = 1; c <= 12; c++) begin
        cycle(rdy, ov, rr, tt);
        if (ov) begin
          lat = c;
          r = rr;
          t = tt;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b want=1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy got=%b want=0", busy); else n_pass++;
`ifdef MUL_ISSUE_CTRL_STATS_EN
    n_checks++; if (stat_ops !== 32'd0) $display("FAIL rst_stat_ops got=%0d want=0", stat_ops); else n_pass++;
    n_checks++; if (stat_stall !== 32'd0) $display("FAIL rst_stat_stall got=%0d want=0", stat_stall); else n_pass++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int lat;
    logic [W-1:0] r;
    logic [TW-1:0] t;
    issue_one(2'b00, 16'h1234, 16'h0010, 4'hA, lat, r, t);
    n_checks++; if (lat != L) $display("FAIL latency got=%0d want=%0d", lat, L); else n_pass++;
    n_checks++; if (r !== 16'h2340) $display("FAIL lat_result got=%h want=2340", r); else n_pass++;
    n_checks++; if (t !== 4'hA) $display("FAIL lat_tag got=%h want=a", t); else n_pass++;
  endtask

  task automatic test_opcodes();
    logic [1:0]  ops  [11] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01,
                               2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [15:0] va   [11] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF,
                               16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h0003};
    logic [15:0] vb   [11] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFFF, 16'h7FFF,
                               16'hFFFF, 16'h7FFF, 16'h0002, 16'h0002, 16'h8000};
    logic [15:0] vexp [11] = '{16'h4000, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h7FFE, 16'h3FFF,
                               16'h0001, 16'hC000, 16'hFFFF, 16'h0001, 16'h0001};
    int lat;
    logic [W-1:0] r;
    logic [TW-1:0] t;
    for (int i = 0; i < 11; i++) begin
      issue_one(ops[i], va[i], vb[i], TW'(i + 3), lat, r, t);
      n_checks++;
      if (r !== vexp[i] || lat != L)
        $display("FAIL opcode_%0d op=%b a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, ops[i], va[i], vb[i], r, lat, vexp[i], L);
      else n_pass++;
      n_checks++; if (t !== TW'(i + 3)) $display("FAIL opcode_tag_%0d got=%h want=%h", i, t, TW'(i + 3)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, ov;
    logic [W-1:0] r, a, b;
    logic [TW-1:0] t;
    int sent = 0, got = 0, first = -1, last = -1;
    bit ready_dropped = 0;
    exp_r.delete(); exp_t.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 8; c++) begin
      a = W'(16'h1357 * (sent + 1));
      b = W'(16'hF00D ^ (sent * 16'h0123));
      in_valid = (sent < 8);
      in_op = 2'(sent); in_a = a; in_b = b; in_tag = TW'(sent);
      cycle(rdy, ov, r, t);
      if (in_valid) begin
        if (!rdy) ready_dropped = 1;
        else begin
          exp_r.push_back(golden(2'(sent), a, b));
          exp_t.push_back(TW'(sent));
          sent++;
        end
      end
      if (ov) begin
        if (first < 0) first = c;
        last = c;
        got++;
        n_checks++;
        if (exp_r.size() == 0) $display("FAIL b2b_spurious got=%h want=none", r);
        else if (r !== exp_r[0] || t !== exp_t[0])
          $display("FAIL b2b_data got=%h/%h want=%h/%h", r, t, exp_r[0], exp_t[0]);
        else n_pass++;
        if (exp_r.size() != 0) begin void'(exp_r.pop_front()); void'(exp_t.pop_front()); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (ready_dropped) $display("FAIL b2b_in_ready got=dropped want=held"); else n_pass++;
    n_checks++; if (got != 8) $display("FAIL b2b_count got=%0d want=8", got); else n_pass++;
    n_checks++; if (first != L || last != L + 7) $display("FAIL b2b_rate got=%0d..%0d want=%0d..%0d", first, last, L, L + 7); else n_pass++;
  endtask

  task automatic test_stall();
    logic rdy, ov;
    logic [W-1:0] r, a, b, held_r;
    logic [TW-1:0] t, held_t;
    int acc = 0, pops = 0, seq = 0;
    bit seen = 0, unstable = 0;
    exp_r.delete(); exp_t.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a = W'(16'h2468 + seq * 16'h1111);
      b = W'(16'h8001 - seq * 16'h0707);
      in_valid = 1'b1; in_op = 2'(seq + 1); in_a = a; in_b = b; in_tag = TW'(seq + 8);
      cycle(rdy, ov, r, t);
      if (rdy) begin
        exp_r.push_back(golden(2'(seq + 1), a, b));
        exp_t.push_back(TW'(seq + 8));
        seq++;
        acc++;
      end
      if (seen && (!ov || r !== held_r || t !== held_t)) unstable = 1;
      if (ov && !seen) begin seen = 1; held_r = r; held_t = t; end
    end
    n_checks++; if (acc != DEPTH) $display("FAIL stall_accepts got=%0d want=%0d", acc, DEPTH); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", rdy); else n_pass++;
    n_checks++; if (!seen || unstable) $display("FAIL stall_hold got=seen%0d_unstable%0d want=seen1_unstable0", seen, unstable); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (c < 6 || exp_r.size() != 0); c++) begin
      a = W'(16'h0F0F * (seq + 1));
      b = W'(16'hA5A5 + seq);
      in_valid = (c < 6); in_op = 2'(seq); in_a = a; in_b = b; in_tag = TW'(seq + 8);
      cycle(rdy, ov, r, t);
      if (in_valid && rdy) begin
        exp_r.push_back(golden(2'(seq), a, b));
        exp_t.push_back(TW'(seq + 8));
        seq++;
        acc++;
      end
      if (ov) begin
        pops++;
        n_checks++;
        if (exp_r.size() == 0) $display("FAIL stall_spurious got=%h want=none", r);
        else if (r !== exp_r[0] || t !== exp_t[0])
          $display("FAIL stall_order got=%h/%h want=%h/%h", r, t, exp_r[0], exp_t[0]);
        else n_pass++;
        if (exp_r.size() != 0) begin void'(exp_r.pop_front()); void'(exp_t.pop_front()); end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (pops != acc || acc <= DEPTH) $display("FAIL stall_drain got=%0d/%0d want=all_of_more_than_%0d", pops, acc, DEPTH); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic rdy, ov;
    logic [W-1:0] r;
    logic [TW-1:0] t;
    int acc = 0, stale = 0, lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'(i); in_a = 16'hBEEF; in_b = 16'h0103; in_tag = TW'(i);
      cycle(rdy, ov, r, t);
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    n_checks++; if (acc != 3) $display("FAIL rmid_accepts got=%0d want=3", acc); else n_pass++;
    rst = 1'b1;
    cycle(rdy, ov, r, t);
    n_checks++; if (rdy !== 1'b0) $display("FAIL rmid_in_ready got=%b want=0", rdy); else n_pass++;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b want=0", busy); else n_pass++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      cycle(rdy, ov, r, t);
      if (ov) stale++;
    end
    n_checks++; if (stale != 0) $display("FAIL rmid_stale got=%0d want=0", stale); else n_pass++;
    issue_one(2'b11, 16'h1234, 16'h5678, 4'h6, lat, r, t);
    n_checks++; if (r !== 16'h0626 || lat != L) $display("FAIL rmid_new got=%h lat=%0d want=0626 lat=%0d", r, lat, L); else n_pass++;
    n_checks++; if (t !== 4'h6) $display("FAIL rmid_new_tag got=%h want=6", t); else n_pass++;
  endtask

  task automatic test_random();
    logic rdy, ov, prev_stall;
    logic [W-1:0] r, a, b, prev_r;
    logic [TW-1:0] t, prev_t;
    logic [1:0] op;
    int occ_m = 0, seq = 0;
    exp_r.delete(); exp_t.delete();
    prev_stall = 1'b0; prev_r = '0; prev_t = '0;
    for (int c = 0; c < 460; c++) begin
      bit draining;
      draining = (c >= 400);
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: a = 16'hFFFF;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h8000;
        1: b = 16'hFFFF;
        default: b = W'($urandom);
      endcase
      in_valid  = !draining && ($urandom_range(0, 3) != 0);
      out_ready = draining || ($urandom_range(0, 3) != 0);
      in_op = op; in_a = a; in_b = b; in_tag = TW'(seq);
      cycle(rdy, ov, r, t);
      n_checks++; if (rdy !== (occ_m < DEPTH)) $display("FAIL rnd_in_ready c=%0d got=%b want=%b", c, rdy, occ_m < DEPTH); else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (ov !== 1'b1 || r !== prev_r || t !== prev_t)
          $display("FAIL rnd_hold c=%0d got=%b/%h/%h want=1/%h/%h", c, ov, r, t, prev_r, prev_t);
        else n_pass++;
      end
      if (in_valid && rdy) begin
        exp_r.push_back(golden(op, a, b));
        exp_t.push_back(TW'(seq));
        seq++;
        occ_m++;
      end
      if (ov && out_ready) begin
        n_checks++;
        if (exp_r.size() == 0) $display("FAIL rnd_spurious c=%0d got=%h want=none", c, r);
        else if (r !== exp_r[0] || t !== exp_t[0])
          $display("FAIL rnd_data c=%0d got=%h/%h want=%h/%h", c, r, t, exp_r[0], exp_t[0]);
        else n_pass++;
        if (exp_r.size() != 0) begin void'(exp_r.pop_front()); void'(exp_t.pop_front()); end
        occ_m--;
      end
      prev_stall = ov && !out_ready;
      prev_r = r;
      prev_t = t;
    end
    in_valid = 1'b0;
    n_checks++; if (exp_r.size() != 0) $display("FAIL rnd_drain got=%0d_left want=0", exp_r.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rnd_busy got=%b want=0", busy); else n_pass++;
`ifdef MUL_ISSUE_CTRL_STATS_EN
    n_checks++; if (stat_ops !== n_acc) $display("FAIL stat_ops got=%0d want=%0d", stat_ops, n_acc); else n_pass++;
    n_checks++; if (stat_stall !== n_stall) $display("FAIL stat_stall got=%0d want=%0d", stat_stall, n_stall); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_opcodes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
